// File: rtl/rti_core.sv
// Real-time input capture core: synchronizes N input lines, detects enabled edges
// and queues {timestamp, edge mask, level} words in a FIFO drained by the host.
module rti_core #(
    parameter int N           = 16,
    parameter int DEPTH       = 1024,
    parameter int FULL_THRESH = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     auto_start,
    input  logic                     flush,
    input  logic [N-1:0]             sig_in,
    input  logic [N-1:0]             rise_en,
    input  logic [N-1:0]             fall_en,
    input  logic [63:0]              counter,
    input  logic                     rd_en,
    output logic [127:0]             rti_out,
    output logic                     rti_out_valid,
    output logic                     overflow_error,
    output logic [127:0]             overflow_error_data,
    output logic                     underflow_error,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]   s1_q, s2_q, prev_q;
    logic [1:0]     prime_cnt_q, prime_cnt_d;
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic [127:0]   ovf_data_q, ovf_data_d;
    logic           udf_q, udf_d;
    logic           out_seen_q, out_seen_d;
    logic [127:0]   rd_word_q;
    logic [127:0]   mem [DEPTH];

    logic [N-1:0]   rise_s, fall_s, chg_s;
    logic [31:0]    chg_ext_s, lvl_ext_s;
    logic [127:0]   word_s;
    logic           primed_s, event_s, full_s, empty_s;
    logic           push_s, ovf_s, rd_s, udf_s;

    // Edge detection, FIFO control decisions and next-state computation.
    always_comb begin
        rise_s    = s2_q & ~prev_q;
        fall_s    = ~s2_q & prev_q;
        chg_s     = (rise_s & rise_en) | (fall_s & fall_en);
        chg_ext_s = 32'h0000_0000;
        chg_ext_s[N-1:0] = chg_s;
        lvl_ext_s = 32'h0000_0000;
        lvl_ext_s[N-1:0] = s2_q;
        word_s    = {counter, chg_ext_s, lvl_ext_s};

        // The pipeline starts from zero, so edges seen before it refills are not real.
        primed_s  = (prime_cnt_q == 2'd3);
        event_s   = (chg_s != {N{1'b0}}) && primed_s;
        full_s    = (count_q >= CW'(FULL_THRESH));
        empty_s   = (count_q == {CW{1'b0}});

        push_s    = event_s && auto_start && !full_s && !flush;
        ovf_s     = event_s && auto_start && full_s && !flush;
        rd_s      = rd_en && !empty_s && !flush;
        udf_s     = rd_en && empty_s && !flush;

        prime_cnt_d = primed_s ? 2'd3 : (prime_cnt_q + 2'd1);

        if (flush) begin
            wptr_d  = {AW{1'b0}};
            rptr_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
            rptr_d = rd_s ? (rptr_q + AW'(1)) : rptr_q;
            case ({push_s, rd_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        valid_d    = rd_s;
        ovf_d      = ovf_s;
        ovf_data_d = ovf_s ? word_s : ovf_data_q;
        udf_d      = udf_s;
        out_seen_d = out_seen_q | rd_s;
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= {N{1'b0}};
            s2_q        <= {N{1'b0}};
            prev_q      <= {N{1'b0}};
            prime_cnt_q <= 2'd0;
            wptr_q      <= {AW{1'b0}};
            rptr_q      <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_data_q  <= 128'h0;
            udf_q       <= 1'b0;
            out_seen_q  <= 1'b0;
        end else begin
            s1_q        <= sig_in;
            s2_q        <= s1_q;
            prev_q      <= s2_q;
            prime_cnt_q <= prime_cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            ovf_data_q  <= ovf_data_d;
            udf_q       <= udf_d;
            out_seen_q  <= out_seen_d;
        end
    end

    // Simple dual-port RAM write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wptr_q] <= word_s;
        end
    end

    // Synchronous RAM read port; holds between reads.
    always_ff @(posedge clk) begin
        if (rd_s) begin
            rd_word_q <= mem[rptr_q];
        end
    end

    // Read data is masked until the first read so reset shows zero without resetting the RAM port.
    assign rti_out             = rd_word_q & {128{out_seen_q}};
    assign rti_out_valid       = valid_q;
    assign overflow_error      = ovf_q;
    assign overflow_error_data = ovf_data_q;
    assign underflow_error     = udf_q;
    assign full                = full_s;
    assign empty               = empty_s;
    assign count               = count_q;
endmodule

// File: tb/tb_rti_core.sv
// Bench for rti_core: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized soak with a mid-run reset.
module tb_rti_core;
    localparam int N  = 16;
    localparam int DP = 8;
    localparam int FT = 6;

    logic clk = 1'b0;
    logic reset_n, auto_start, flush, rd_en;
    logic [N-1:0] sig_in, rise_en, fall_en;
    logic [63:0] counter;
    logic [127:0] rti_out, overflow_error_data;
    logic rti_out_valid, overflow_error, underflow_error, full, empty;
    logic [$clog2(DP):0] count;

    rti_core #(.N(N), .DEPTH(DP), .FULL_THRESH(FT)) dut (
        .clk(clk), .reset_n(reset_n), .auto_start(auto_start), .flush(flush),
        .sig_in(sig_in), .rise_en(rise_en), .fall_en(fall_en), .counter(counter),
        .rd_en(rd_en), .rti_out(rti_out), .rti_out_valid(rti_out_valid),
        .overflow_error(overflow_error), .overflow_error_data(overflow_error_data),
        .underflow_error(underflow_error), .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid, n_ovf, n_udf;

    // Reference model: sample history, FIFO contents, expected registered outputs.
    logic [N-1:0] samp [$];
    logic [127:0] fifo [$];
    int           nedge;
    logic [127:0] exp_out, exp_ovf_data;
    logic         exp_valid, exp_ovf, exp_udf;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic reset_model();
        samp = '{16'h0, 16'h0, 16'h0};
        fifo.delete();
        nedge = 0;
        exp_out = 128'h0; exp_ovf_data = 128'h0;
        exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    endtask

    // Decide what the upcoming clock edge must do, from the current inputs.
    task automatic model_eval();
        logic [N-1:0] lvl, old, chg;
        logic [127:0] word;
        bit ev, was_full, was_empty;
        lvl  = samp[1];
        old  = samp[2];
        chg  = ((lvl & ~old) & rise_en) | ((~lvl & old) & fall_en);
        ev   = (chg != 16'h0) && (nedge >= 3);
        word = {counter, 16'h0, chg, 16'h0, lvl};
        was_full  = fifo.size() >= FT;
        was_empty = fifo.size() == 0;
        exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        if (flush) begin
            fifo.delete();
        end else begin
            if (rd_en && !was_empty) begin
                exp_out = fifo.pop_front();
                exp_valid = 1'b1;
            end
            if (rd_en && was_empty) exp_udf = 1'b1;
            if (ev && auto_start) begin
                if (!was_full) fifo.push_back(word);
                else begin
                    exp_ovf = 1'b1;
                    exp_ovf_data = word;
                end
            end
        end
        samp.push_front(sig_in);
        void'(samp.pop_back());
        nedge++;
    endtask

    task automatic compare();
        chk("rti_out", rti_out, exp_out);
        chk("rti_out_valid", rti_out_valid, exp_valid);
        chk("overflow_error", overflow_error, exp_ovf);
        chk("overflow_error_data", overflow_error_data, exp_ovf_data);
        chk("underflow_error", underflow_error, exp_udf);
        chk("count", count, fifo.size());
        chk("full", full, fifo.size() >= FT);
        chk("empty", empty, fifo.size() == 0);
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        counter = counter + 64'd1;
        n_valid += int'(rti_out_valid);
        n_ovf   += int'(overflow_error);
        n_udf   += int'(underflow_error);
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        counter = 64'd0;
        compare();
    endtask

    // Toggle one line and let the event reach the FIFO; returns the cycle it was driven.
    task automatic tog(input int b, output logic [63:0] ts);
        sig_in[b] = ~sig_in[b];
        ts = counter;
        steps(3);
    endtask

    initial begin
        logic [63:0] ts, t8;
        reset_n = 1'b0; auto_start = 1'b0; flush = 1'b0; rd_en = 1'b0;
        sig_in = 16'h0; rise_en = 16'h0; fall_en = 16'h0; counter = 64'd0;
        n_valid = 0; n_ovf = 0; n_udf = 0;
        do_reset();
        chk("reset_count", count, 4'd0);
        chk("reset_empty", empty, 1'b1);
        chk("reset_full", full, 1'b0);
        chk("reset_rti_out", rti_out, 128'h0);

        // Rise detection with timestamp.
        auto_start = 1'b1; rise_en = 16'h0001;
        while (counter < 64'd100) step();
        sig_in[0] = 1'b1;
        steps(4);
        chk("rise_count", count, 4'd1);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        ts = rti_out[127:64];
        chk("rise_ts_102_or_103", (ts == 64'd102) || (ts == 64'd103), 1'b1);
        chk("rise_chg_bit", rti_out[32], 1'b1);
        chk("rise_lvl_bit", rti_out[0], 1'b1);
        sig_in[0] = 1'b0;
        steps(5);
        chk("fall_disabled_count", count, 4'd0);

        // Multi-bit edges.
        rise_en = 16'hFFFF; fall_en = 16'hFFFF;
        sig_in = sig_in ^ 16'h0088; steps(3);
        sig_in = sig_in ^ 16'h0008; steps(3);
        rd_en = 1'b1; step();
        chk("multi_chg", rti_out[63:32], 32'h88);
        step(); rd_en = 1'b0;
        chk("multi_chg2", rti_out[63:32], 32'h8);
        chk("multi_lvl3", rti_out[3], 1'b0);

        // Overflow: eight events, no reads.
        n_ovf = 0; t8 = 64'd0;
        for (int i = 0; i < 8; i++) begin
            sig_in[0] = ~sig_in[0];
            t8 = counter;
            steps(2);
        end
        steps(2);
        chk("ovf_count", count, 4'd6);
        chk("ovf_full", full, 1'b1);
        chk("ovf_pulses", n_ovf, 2);
        chk("ovf_data_ts", overflow_error_data[127:64], t8 + 64'd2);
        chk("ovf_data_chg", overflow_error_data[63:32], 32'h1);

        // Read path: three words, four reads.
        flush = 1'b1; step(); flush = 1'b0;
        tog(1, ts); tog(1, ts); tog(1, ts);
        n_valid = 0; n_udf = 0;
        rd_en = 1'b1; steps(4); rd_en = 1'b0;
        chk("rd_valid_pulses", n_valid, 3);
        chk("rd_underflow_pulses", n_udf, 1);
        chk("rd_keeps_third_ts", rti_out[127:64], ts + 64'd2);

        // Simultaneous push and read at count=2.
        tog(2, ts); tog(2, t8);
        sig_in[2] = ~sig_in[2];
        steps(2);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("simul_count", count, 4'd2);
        chk("simul_oldest", rti_out[127:64], ts + 64'd2);

        // Flush with count=5 and a concurrent event.
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 5; i++) tog(4, ts);
        chk("flush_pre_count", count, 4'd5);
        sig_in[5] = ~sig_in[5];
        steps(2);
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_count", count, 4'd0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_no_ovf", overflow_error, 1'b0);

        // All-ones across reset release must not create events.
        sig_in = 16'hFFFF;
        do_reset();
        steps(6);
        chk("primed_no_event", count, 4'd0);

        // Randomized soak with one asynchronous reset mid-burst.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) sig_in = sig_in ^ 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) sig_in = 16'($urandom);
            if ($urandom_range(0, 99) == 0) rise_en = 16'($urandom);
            if ($urandom_range(0, 99) == 0) fall_en = 16'($urandom);
            auto_start = ($urandom_range(0, 9) != 0);
            rd_en = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 59) == 0);
            step();
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1;
                chk("async_rst_rti_out", rti_out, 128'h0);
                chk("async_rst_valid", rti_out_valid, 1'b0);
                chk("async_rst_ovf", overflow_error, 1'b0);
                chk("async_rst_ovf_data", overflow_error_data, 128'h0);
                chk("async_rst_udf", underflow_error, 1'b0);
                chk("async_rst_count", count, 4'd0);
                chk("async_rst_empty", empty, 1'b1);
                chk("async_rst_full", full, 1'b0);
                reset_model();
                @(negedge clk);
                reset_n = 1'b1;
                compare();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rti_core.md
Name: rti_core

Overview:
- Real-time input capture core; the receive-side counterpart of the timestamped output core.
- Samples N asynchronous input lines and detects enabled rising/falling edges.
- On each event, pushes a 128-bit word {counter timestamp, edge mask, level} into an internal FIFO.
- The host drains the FIFO through a read strobe; overflow and underflow are reported with sticky-free pulse flags and captured data.

Parameters:
- N, 16, number of input lines; legal range 1..32.
- DEPTH, 1024, FIFO depth in 128-bit words; power of two, minimum 4.
- FULL_THRESH, 1000, occupancy at which full asserts; legal range 1..DEPTH-1.

Ports:
- clk  in  1  single core clock.
- reset_n  in  1  asynchronous, active-low reset.
- auto_start  in  1  capture enable; events are discarded while low.
- flush  in  1  synchronous FIFO clear.
- sig_in  in  N  asynchronous input lines.
- rise_en  in  N  per-bit rising-edge enable.
- fall_en  in  N  per-bit falling-edge enable.
- counter  in  64  free-running timestamp counter.
- rd_en  in  1  host read strobe.
- rti_out  out  128  last word read from the FIFO.
- rti_out_valid  out  1  one-cycle pulse marking a new rti_out.
- overflow_error  out  1  one-cycle pulse: event dropped because the FIFO was full.
- overflow_error_data  out  128  the dropped word.
- underflow_error  out  1  one-cycle pulse: rd_en asserted while empty.
- full  out  1  count >= FULL_THRESH.
- empty  out  1  count == 0.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers clear: synchronizer, previous-level register, FIFO pointers and count, rti_out, overflow_error_data.
  - All pulses are 0; empty=1, full=0.
  - Release is synchronous to clk in the integrating design.
- Synchronizer: two flops per bit, s1 then s2. A third register, prev, holds the previous s2.
- Edge detection (cycle T):
  - rise = s2 & ~prev; fall = ~s2 & prev.
  - chg = (rise & rise_en) | (fall & fall_en).
  - Event when chg != 0 and primed == 1.
- primed: cleared by reset; set on the third clk edge after reset_n rises. This suppresses spurious edges from the zero-initialised pipeline.
- Word format, formed in cycle T:
  - [127:64] = counter in cycle T.
  - [63:32] = chg zero-extended.
  - [31:0] = s2 zero-extended.
  - Unused bits are 0.
  - Input-to-timestamp latency is 2-3 clk (synchronizer); it is not compensated.
- Push (registered at the end of cycle T): event && auto_start && ~full && ~flush.
  - mem[wptr] <= word; wptr increments modulo DEPTH.
- Overflow: event && auto_start && full && ~flush.
  - Word is dropped.
  - Next cycle: overflow_error=1 and overflow_error_data=word.
  - overflow_error_data holds until the next overflow or reset.
- Events with auto_start low are dropped silently: no error, edge state still updates.
- Read: rd_en && ~empty && ~flush.
  - Next cycle: rti_out=mem[rptr] and rti_out_valid=1; rptr increments.
  - rti_out holds its value between reads.
- Underflow: rd_en && empty.
  - Next cycle: underflow_error=1; rti_out unchanged; rti_out_valid=0.
- Simultaneous push and read in one cycle: both occur; count unchanged.
- Read-after-write when empty: a word pushed in cycle T is readable from cycle T+1. rd_en in cycle T with empty=1 is an underflow, even if a push occurs in T.
- full and empty are combinational from the registered count.
  - full is a soft threshold: DEPTH-FULL_THRESH words of headroom are never written.
  - The count never exceeds FULL_THRESH.
- Flush (synchronous, highest priority after reset):
  - Next cycle: wptr=rptr=count=0.
  - Any push/read in the same cycle is cancelled; no error pulses.
  - rti_out and overflow_error_data are retained.
  - The edge-detection state is not cleared.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count is the sole source of full and empty.
- Memory is inferred as simple dual-port RAM with a synchronous read.

Test Plan:
- Rise detection: reset, auto_start=1, rise_en=16'h0001, fall_en=0, counter increments from 0.
  - Drive sig_in[0] 0->1 at counter=100.
  - Expect one word with [127:64]=102 or 103, [32]=1, [0]=1.
  - Drive sig_in[0] 1->0: expect no push (fall disabled).
- Multi-bit edges: rise_en=fall_en=16'hFFFF.
  - Toggle bits 3 and 7 simultaneously: expect one word with [63:32]=32'h88.
  - Toggle bit 3 back: expect a second word with [63:32]=32'h8 and [3]=0.
- Overflow: DEPTH=8, FULL_THRESH=6, no reads, 8 events.
  - Expect count to stop at 6 with full=1.
  - Expect two overflow_error pulses; overflow_error_data = the 8th event word.
- Read path: 3 stored words, rd_en held 4 cycles.
  - Expect rti_out_valid on 3 consecutive cycles, in FIFO order.
  - The 4th read gives underflow_error=1; rti_out keeps the third word.
- Simultaneous push and read: count=2, event and rd_en in the same cycle.
  - Expect count stays 2, rti_out = oldest word, new word stored.
- Reset and flush:
  - Hold sig_in=all ones across reset release: expect no event (primed gating).
  - Flush with count=5 and a concurrent event: next cycle count=0, empty=1, no overflow pulse.
  - Assert reset_n low mid-burst, asynchronously: all outputs zero immediately.
